// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port among scanout (p0, strict priority),
// rasterizer (p1) and SPI host (p2), with p1/p2 round-robin and starvation promotion.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned ADDR_W       = 24
) (
  input  logic              clk_sram,
  input  logic              rst_n_sram,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_ready,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_ready,
  input  logic              p2_req,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [31:0]       p2_wdata,
  output logic              p2_ack,
  output logic              p2_ready,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic              mem_ready,
  output logic [1:0]        grant_id,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0]  GID_NONE = 2'd3;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t             state;
  logic [1:0]         rr_last;
  logic [CNT_W-1:0]   starve_cnt1;
  logic [CNT_W-1:0]   starve_cnt2;
  logic               promo1;
  logic               promo2;
  logic               grant_fire;
  logic [1:0]         winner;
  logic [1:0]         rr_pick;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [31:0]        sel_wdata;
  logic [CNT_W-1:0]   cnt1_nxt;
  logic [CNT_W-1:0]   cnt2_nxt;

  // Clear on own grant or idle request; saturating bump on each port-0 grant while waiting.
  function automatic logic [CNT_W-1:0] cnt_next(input logic req, input logic fire,
                                                 input logic [1:0] win, input logic [1:0] port,
                                                 input logic [CNT_W-1:0] cnt);
    if (!req || (fire && win == port)) return '0;
    if (fire && win == 2'd0 && cnt != '1) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  // Winner selection and payload mux.
  always_comb begin
    promo1     = p1_req && (starve_cnt1 >= CNT_W'(STARVE_LIMIT));
    promo2     = p2_req && (starve_cnt2 >= CNT_W'(STARVE_LIMIT));
    grant_fire = (state == IDLE) && mem_ready && (p0_req || p1_req || p2_req);
    rr_pick    = (rr_last == 2'd1) ? 2'd2 : 2'd1;
    winner     = 2'd2;
    if (promo1 && promo2)          winner = rr_pick;
    else if (promo1)               winner = 2'd1;
    else if (promo2)               winner = 2'd2;
    else if (p0_req)               winner = 2'd0;
    else if (p1_req && p2_req)     winner = rr_pick;
    else if (p1_req)               winner = 2'd1;

    sel_we    = 1'b0;
    sel_addr  = p2_addr;
    sel_wdata = p2_wdata;
    case (winner)
      2'd0:    begin sel_we = 1'b0;  sel_addr = p0_addr; sel_wdata = p0_wdata; end
      2'd1:    begin sel_we = p1_we; sel_addr = p1_addr; sel_wdata = p1_wdata; end
      default: begin sel_we = p2_we; sel_addr = p2_addr; sel_wdata = p2_wdata; end
    endcase

    cnt1_nxt = cnt_next(p1_req, grant_fire, winner, 2'd1, starve_cnt1);
    cnt2_nxt = cnt_next(p2_req, grant_fire, winner, 2'd2, starve_cnt2);
  end

  always_ff @(posedge clk_sram) begin
    if (!rst_n_sram) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      grant_id    <= GID_NONE;
      rr_last     <= 2'd2;
      starve_cnt1 <= '0;
      starve_cnt2 <= '0;
    end else begin
      starve_cnt1 <= cnt1_nxt;
      starve_cnt2 <= cnt2_nxt;
      unique case (state)
        IDLE: begin
          if (grant_fire) begin
            state     <= WAIT_ACK;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            grant_id  <= winner;
            if (winner != 2'd0) rr_last <= winner;
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            state   <= IDLE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            rdata   <= mem_rdata;
          end
        end
      endcase
    end
  end

  assign p0_ack   = (state == WAIT_ACK) && mem_ack && (grant_id == 2'd0);
  assign p1_ack   = (state == WAIT_ACK) && mem_ack && (grant_id == 2'd1);
  assign p2_ack   = (state == WAIT_ACK) && mem_ack && (grant_id == 2'd2);
  assign p0_ready = (state == IDLE) && mem_ready;
  assign p1_ready = (state == IDLE) && mem_ready;
  assign p2_ready = (state == IDLE) && mem_ready;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model with an in-bench SRAM responder.
module tb_sram_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned AW    = 24;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } txn_t;

  logic          clk_sram = 1'b0;
  logic          rst_n_sram;
  logic          p_req [3];
  logic          p_we [3];
  logic [AW-1:0] p_addr [3];
  logic [31:0]   p_wdata [3];
  logic          p0_ack, p1_ack, p2_ack, p0_ready, p1_ready, p2_ready;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, mem_ready, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant_id;

  always #5 clk_sram = ~clk_sram;

  sram_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
    .clk_sram(clk_sram), .rst_n_sram(rst_n_sram),
    .p0_req(p_req[0]), .p0_we(p_we[0]), .p0_addr(p_addr[0]), .p0_wdata(p_wdata[0]),
    .p0_ack(p0_ack), .p0_ready(p0_ready),
    .p1_req(p_req[1]), .p1_we(p_we[1]), .p1_addr(p_addr[1]), .p1_wdata(p_wdata[1]),
    .p1_ack(p1_ack), .p1_ready(p1_ready),
    .p2_req(p_req[2]), .p2_we(p_we[2]), .p2_addr(p_addr[2]), .p2_wdata(p_wdata[2]),
    .p2_ack(p2_ack), .p2_ready(p2_ready),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_ready(mem_ready), .grant_id(grant_id), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Requester queues, SRAM contents and reference-model state.
  txn_t          q [3][$];
  logic [31:0]   sram [logic [AW-1:0]];
  bit            ack_prev [3];
  int            ack_cnt [3];
  int            glog [$];
  bit            prev_mreq;
  bit            last_we;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_wdata;
  int            lat = 3;
  bit            rand_lat, stray_en;
  int            sram_wait;

  bit            m_busy, m_mreq, m_mwe;
  int            m_gid, m_rr;
  int            m_cnt [3];
  logic [AW-1:0] m_maddr;
  logic [31:0]   m_mwdata, m_rdata;

  function automatic void model_reset();
    m_busy = 0; m_mreq = 0; m_mwe = 0; m_gid = 3; m_rr = 2;
    m_maddr = '0; m_mwdata = '0; m_rdata = '0;
    for (int p = 0; p < 3; p++) m_cnt[p] = 0;
  endfunction

  function automatic logic [31:0] sram_read(input logic [AW-1:0] a);
    if (sram.exists(a)) return sram[a];
    return 32'(a) ^ 32'h5A5A_0000;
  endfunction

  // Promoted ports first, then port 0, then whichever of 1/2 was not served last.
  function automatic int pick();
    bit pr1   = p_req[1] && (m_cnt[1] >= int'(LIMIT));
    bit pr2   = p_req[2] && (m_cnt[2] >= int'(LIMIT));
    int other = (m_rr == 1) ? 2 : 1;
    if (pr1 && pr2) return other;
    if (pr1) return 1;
    if (pr2) return 2;
    if (p_req[0]) return 0;
    if (p_req[1] && p_req[2]) return other;
    return p_req[1] ? 1 : 2;
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step();
    bit exp_ack [3];
    bit fire;
    int win = -1;
    logic [3:0] dut_ack;
    for (int p = 0; p < 3; p++) begin
      if (ack_prev[p] && q[p].size() > 0) void'(q[p].pop_front());
      p_req[p] = (q[p].size() > 0);
      if (p_req[p]) begin
        p_we[p] = q[p][0].we; p_addr[p] = q[p][0].addr; p_wdata[p] = q[p][0].wdata;
      end
    end
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (m_busy) begin
      if (sram_wait > 1) sram_wait--;
      else begin mem_ack = 1'b1; mem_rdata = sram_read(m_maddr); end
    end else if (stray_en && $urandom_range(9) == 0) mem_ack = 1'b1;
    if (!rst_n_sram) mem_ack = 1'b0;
    #1;
    for (int p = 0; p < 3; p++) exp_ack[p] = m_busy && mem_ack && (m_gid == p);
    dut_ack = {1'b0, p2_ack, p1_ack, p0_ack};
    for (int p = 0; p < 3; p++) begin
      check_eq($sformatf("p%0d_ack", p), 64'(dut_ack[p]), 64'(exp_ack[p]));
      ack_cnt[p] += int'(dut_ack[p]);
    end
    check_eq("ready", 64'({p0_ready, p1_ready, p2_ready}), {3{!m_busy && mem_ready}});
    check_eq("mem_req", 64'(mem_req), 64'(m_mreq));
    check_eq("mem_we", 64'(mem_we), 64'(m_mwe));
    check_eq("mem_addr", 64'(mem_addr), 64'(m_maddr));
    check_eq("mem_wdata", 64'(mem_wdata), 64'(m_mwdata));
    check_eq("rdata", 64'(rdata), 64'(m_rdata));
    check_eq("grant_id", 64'(grant_id), 64'(m_gid));
    check_eq("busy", 64'(busy), 64'(m_busy));
    if (mem_req === 1'b1 && !prev_mreq) begin
      glog.push_back(int'(grant_id));
      last_we = mem_we; last_addr = mem_addr; last_wdata = mem_wdata;
    end
    prev_mreq = (mem_req === 1'b1);

    if (!rst_n_sram) begin
      model_reset();
      for (int p = 0; p < 3; p++) exp_ack[p] = 0;
    end else begin
      fire = !m_busy && mem_ready && (p_req[0] || p_req[1] || p_req[2]);
      if (fire) win = pick();
      for (int p = 1; p < 3; p++) begin
        if (!p_req[p] || win == p) m_cnt[p] = 0;
        else if (win == 0) m_cnt[p] = (m_cnt[p] < 255) ? m_cnt[p] + 1 : 255;
      end
      if (fire) begin
        m_busy = 1; m_mreq = 1; m_gid = win;
        m_mwe = (win != 0) && p_we[win];
        m_maddr = p_addr[win]; m_mwdata = p_wdata[win];
        if (win != 0) m_rr = win;
        sram_wait = rand_lat ? int'($urandom_range(4, 1)) : lat;
      end else if (m_busy && mem_ack) begin
        if (m_mwe) sram[m_maddr] = m_mwdata;
        m_busy = 0; m_mreq = 0; m_rdata = mem_rdata;
      end
    end
    ack_prev = exp_ack;
    @(negedge clk_sram);
  endtask

  task automatic push(input int p, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    q[p].push_back(t);
  endtask

  task automatic run_until_idle(input string tag, input int max_cyc);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() > 0 || m_busy) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) check_eq({tag, "_timeout"}, 64'(n), 64'(0));
  endtask

  task automatic do_reset();
    rst_n_sram = 1'b0;
    for (int p = 0; p < 3; p++) begin q[p].delete(); ack_prev[p] = 0; ack_cnt[p] = 0; end
    step();
    rst_n_sram = 1'b1;
    glog.delete();
  endtask

  task automatic check_seq(input string tag, input int exp [10], input int n);
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s%0d", tag, i), 64'((i < glog.size()) ? glog[i] : 9), 64'(exp[i]));
  endtask

  initial begin
    int rr_exp [10] = '{1, 2, 1, 2, 1, 2, 1, 2, 0, 0};
    int sv_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int n;
    rst_n_sram = 1'b0; mem_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    for (int p = 0; p < 3; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_addr[p] = '0; p_wdata[p] = '0; ack_prev[p] = 0; ack_cnt[p] = 0;
    end
    rand_lat = 0; stray_en = 0; prev_mreq = 0;
    repeat (2) @(negedge clk_sram);
    model_reset();
    check_eq("rst_mem_req", 64'(mem_req), 64'(0));
    check_eq("rst_grant", 64'(grant_id), 64'(3));
    check_eq("rst_rdata", 64'(rdata), 64'(0));
    check_eq("rst_busy_addr", 64'({busy, mem_we, mem_addr, p0_ack, p1_ack, p2_ack}), 64'(0));
    rst_n_sram = 1'b1;

    // Single read from port 0 (its we must be ignored).
    sram[24'h000100] = 32'hDEAD1234;
    push(0, 1'b1, 24'h000100, 32'h1111_2222);
    run_until_idle("read", 30);
    step();
    check_eq("read_acks", 64'({ack_cnt[0], ack_cnt[1], ack_cnt[2]}), {32'd1, 32'd0, 32'd0});
    check_eq("read_rdata", 64'(rdata), 64'h0000_0000_DEAD_1234);
    check_eq("read_grant", 64'(grant_id), 64'(0));
    check_eq("read_we", 64'(last_we), 64'(0));

    // Single write from port 1.
    for (int p = 0; p < 3; p++) ack_cnt[p] = 0;
    push(1, 1'b1, 24'h012345, 32'hCAFEF00D);
    run_until_idle("write", 30);
    step();
    check_eq("write_we", 64'(last_we), 64'(1));
    check_eq("write_addr", 64'(last_addr), 64'h012345);
    check_eq("write_wdata", 64'(last_wdata), 64'hCAFEF00D);
    check_eq("write_acks", 64'({ack_cnt[0], ack_cnt[1], ack_cnt[2]}), {32'd0, 32'd1, 32'd0});

    // Round-robin between ports 1 and 2 from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(1, 1'b0, AW'(32'h100 + i), '0);
      push(2, 1'b0, AW'(32'h200 + i), '0);
    end
    run_until_idle("rr", 200);
    check_seq("rr_grant", rr_exp, 8);

    // Starvation promotion of port 1 under continuous port-0 traffic.
    do_reset();
    for (int i = 0; i < 10; i++) push(0, 1'b0, AW'(32'h300 + i), '0);
    for (int i = 0; i < 3; i++) push(1, 1'b1, AW'(32'h400 + i), 32'(i));
    run_until_idle("starve", 300);
    check_seq("starve_grant", sv_exp, 10);

    // Reset mid-transaction after a completed read has loaded rdata.
    push(2, 1'b0, 24'h000777, '0);
    run_until_idle("pre_abort", 30);
    push(2, 1'b0, 24'h000888, '0);
    n = 0;
    while (!m_busy && n < 20) begin step(); n++; end
    check_eq("abort_busy", 64'(m_busy), 64'(1));
    step();
    for (int p = 0; p < 3; p++) ack_cnt[p] = 0;
    do_reset();
    check_eq("abort_mem_req", 64'(mem_req), 64'(0));
    check_eq("abort_grant", 64'(grant_id), 64'(3));
    check_eq("abort_rdata", 64'(rdata), 64'(0));
    check_eq("abort_acks", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2]), 64'(0));

    // Backpressure: mem_ready low holds off the grant.
    mem_ready = 1'b0;
    push(2, 1'b1, 24'h000999, 32'h5555_AAAA);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_idle", 64'({mem_req, p0_ready, p1_ready, p2_ready}), 64'(0));
    end
    mem_ready = 1'b1;
    step();
    check_eq("bp_grant_req", 64'(mem_req), 64'(1));
    check_eq("bp_grant_id", 64'(grant_id), 64'(2));
    run_until_idle("bp", 30);

    // Random traffic, latency, backpressure and stray acks.
    rand_lat = 1; stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 3; p++)
        if (q[p].size() < 2 && $urandom_range(3) == 0)
          push(p, 1'($urandom), AW'($urandom), $urandom);
      mem_ready = ($urandom_range(4) != 0);
      step();
    end
    mem_ready = 1'b1; stray_en = 0;
    run_until_idle("rand", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single SRAM controller port among three requesters on the core clock: display scanout (port 0), rasterizer framebuffer/Z traffic (port 1) and SPI host register/memory access (port 2). Each port gets a single-word req/ack interface matching the display controller's SRAM port. Port 0 has strict priority, with a bounded-starvation guard for the low-priority ports. Ports 1 and 2 share the remaining bandwidth round-robin. Sits between the requesters and the SRAM controller in the GPU top level.

## Interface
Parameters:
- STARVE_LIMIT, 16: consecutive port-0 grants a waiting port 1/2 tolerates before it is promoted above port 0 (range 1..255).
- ADDR_W, 24: word address width.

Ports:
- clk_sram  input  1  core clock, 100 MHz.
- rst_n_sram  input  1  reset, synchronous and active-low.
- pN_req  input  1  request, N = 0..2; held high until pN_ack is sampled.
- pN_we  input  1  write enable; p0_we is ignored and treated as 0 (scanout is read-only).
- pN_addr  input  ADDR_W  word address; stable while pN_req is high.
- pN_wdata  input  32  write data; stable while pN_req is high.
- pN_ack  output  1  one-cycle completion pulse for port N.
- pN_ready  output  1  arbiter can start a new transaction.
- rdata  output  32  read data of the most recent completed transaction, shared by all ports.
- mem_req  output  1  request to the SRAM controller.
- mem_we  output  1  write enable to the SRAM controller.
- mem_addr  output  ADDR_W  address to the SRAM controller.
- mem_wdata  output  32  write data to the SRAM controller.
- mem_rdata  input  32  read data from the SRAM controller, valid in the mem_ack cycle.
- mem_ack  input  1  SRAM controller completion pulse.
- mem_ready  input  1  SRAM controller idle.
- grant_id  output  2  owner of the current or last transaction; 3 = none.
- busy  output  1  state is not IDLE.

## Operation
- States: IDLE and WAIT_ACK.
- In IDLE, when mem_ready = 1 and any pN_req = 1:
  - Select a winner and latch it into grant_id.
  - Register the winner's addr, we and wdata onto the mem_* outputs.
  - Set mem_req = 1 and move to WAIT_ACK.
- In WAIT_ACK, when mem_ack = 1:
  - Clear mem_req.
  - Capture mem_rdata into rdata (writes also capture it).
  - Return to IDLE.
- pN_ack = mem_ack when state = WAIT_ACK and grant_id = N; combinational, exactly one cycle.
- Requesters drop pN_req on the edge at which they sample pN_ack. The cycle after an ack therefore never sees a stale request.
- Winner selection:
  - A promoted port (see starvation rule) wins first.
  - Otherwise p0 wins.
  - Otherwise ports 1 and 2 are served round-robin: rr_last records the last of ports 1/2 granted (reset value 2, so port 1 goes first on a tie). When both request, the one not equal to rr_last wins.
- Starvation rule:
  - Each of ports 1 and 2 has an 8-bit starve_cnt.
  - starve_cnt increments, saturating, on every port-0 grant made while that port's req is high.
  - It clears when that port is granted, or when its req is low.
  - Once starve_cnt ≥ STARVE_LIMIT, the port is promoted.
  - If both ports are promoted, the round-robin rule picks between them.
- pN_ready = (state == IDLE) && mem_ready, identical for all N.
- rdata holds its value until the next mem_ack.
- A mem_ack arriving in IDLE is ignored: no pN_ack pulse and no rdata update.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, grant_id 3, rr_last 2, starve_cnt 0, busy 0. All pN_ack outputs are 0.
- Reset asserted mid-transaction aborts it: no pN_ack is emitted, and the SRAM controller is expected to be reset together with the arbiter.
- Grant latency:
  - A request present at edge k with state IDLE and mem_ready = 1 produces mem_req = 1 after edge k.
  - pN_ack coincides with mem_ack.
  - rdata is valid from the edge after ack.
- Minimum turnaround is 1 IDLE cycle between transactions, so the maximum rate is one transaction per (SRAM latency + 1) cycles.
- Simultaneous events:
  - A new request arriving in the ack cycle is evaluated in the following IDLE cycle.
  - Arrivals while in WAIT_ACK wait for IDLE.
- mem_we is forced to 0 whenever grant_id = 0.

## Test plan
- **Single read:** p0 reads addr 0x000100 while the SRAM model returns 0xDEAD1234 after 3 cycles.
  - p0_ack pulses once, 1 cycle wide.
  - rdata = 0xDEAD1234 from the next cycle.
  - grant_id = 0.
- **Single write:** p1 writes 0xCAFEF00D to 0x012345.
  - mem_we = 1, mem_addr = 0x012345, mem_wdata = 0xCAFEF00D.
  - Only p1_ack pulses.
- **Round-robin:** p1 and p2 request continuously with p0 idle.
  - Grants alternate 1, 2, 1, 2, starting with port 1 after reset.
- **Starvation, STARVE_LIMIT = 4:** p0 and p1 request continuously.
  - Grant sequence is 0, 0, 0, 0, 1, 0, 0, 0, 0, 1.
- **Reset mid-transaction:** rst_n_sram = 0 while in WAIT_ACK.
  - Next cycle: mem_req = 0, no ack, grant_id = 3, rdata = 0.
- **Backpressure:** mem_ready = 0 for 10 cycles while p2 is requesting.
  - No mem_req and all pN_ready = 0 during that window.
  - Grant follows 1 cycle after mem_ready rises.
